bus_rr_arbiter: RTL and testbench

Round-robin bus arbiter for the four masters of the shared system bus. It decides which master owns the bus and drives the one-hot grant lines that feed the master multiplexer. The decision is fair, registered and glitch-free. It also provides an optional hold-limit that forcibly rotates ownership away from a master that monopolises the bus while others wait.

---
 rtl/bus_rr_arbiter_pkg.sv | 31 +++
 rtl/bus_rr_arbiter_if.sv | 34 +++
 rtl/bus_rr_arbiter_rr_pick4.sv | 34 +++
 rtl/bus_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_rr_arbiter_pkg
//   Shared constants and types for the four-master round-robin bus arbiter:
//   master count, grant-id width, FSM state encodings, the HOLD_MAX default
//   and a one-hot to index helper.
// ----------------------------------------------------------------------------
package bus_rr_arbiter_pkg;

  localparam int NUM_MASTERS  = 4;
  localparam int GRNT_ID_W    = 2;
  localparam int HOLD_CNT_W   = 8;
  localparam int HOLD_MAX_DEF = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Index of the set bit of a one-hot vector (0 for an all-zero vector).
  function automatic logic [GRNT_ID_W-1:0] onehot_to_id(
    input logic [NUM_MASTERS-1:0] oh
  );
    logic [GRNT_ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) id = id | GRNT_ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_rr_arbiter_if
//   Request/grant bundle between the four bus masters and the arbiter.
//   modport master : the requesting side (drives req, observes grants)
//   modport slave  : the arbiter side (observes req, drives grants/status)
//   Signals: m0_req..m3_req, m0_grnt..m3_grnt, grnt_id, grnt_vld,
//   arb_preempt.
// ----------------------------------------------------------------------------
interface bus_rr_arbiter_if;
  import bus_rr_arbiter_pkg::*;

  logic                 m0_req;
  logic                 m1_req;
  logic                 m2_req;
  logic                 m3_req;
  logic                 m0_grnt;
  logic                 m1_grnt;
  logic                 m2_grnt;
  logic                 m3_grnt;
  logic [GRNT_ID_W-1:0] grnt_id;
  logic                 grnt_vld;
  logic                 arb_preempt;

  modport master (
    output m0_req, m1_req, m2_req, m3_req,
    input  m0_grnt, m1_grnt, m2_grnt, m3_grnt, grnt_id, grnt_vld, arb_preempt
  );

  modport slave (
    input  m0_req, m1_req, m2_req, m3_req,
    output m0_grnt, m1_grnt, m2_grnt, m3_grnt, grnt_id, grnt_vld, arb_preempt
  );

endinterface

// File: rtl/bus_rr_arbiter_rr_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4
//   Combinational round-robin picker for four requesters.
//   req   : request vector
//   start : pointer; search order is start+1, start+2, start+3, start (mod 4)
//   excl  : when set, the start position itself is never picked
//   pick  : one-hot winner (zero when nothing found)
//   found : a winner exists
// ----------------------------------------------------------------------------
module rr_pick4
  import bus_rr_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GRNT_ID_W-1:0]   start,
  input  logic                   excl,
  output logic [NUM_MASTERS-1:0] pick,
  output logic                   found
);

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      logic [GRNT_ID_W-1:0] idx;
      // 2-bit add wraps naturally; k == 4 lands back on start.
      idx = start + GRNT_ID_W'(k);
      if (!found && req[idx] && !(excl && (k == NUM_MASTERS))) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// ----------------------------------------------------------------------------
// bus_rr_arbiter
//   Fair round-robin arbiter for the four masters of the shared system bus.
//   Grants are registered and one-hot; ownership passes directly from owner
//   to owner on a single edge.
//
//   Parameters: HOLD_MAX  max saturated hold count before a forced handoff
//                         (hold-limit build only), legal 2..255
//   Ports:      clk       system clock, rising edge
//               rest      asynchronous active-low reset
//               bus       bus_rr_arbiter_if.slave: m*_req in; m*_grnt,
//                         grnt_id, grnt_vld, arb_preempt out
//
//   Build option: define BUS_ARB_HOLD_LIMIT_EN to enable the hold-limit
//   counter and the arb_preempt pulse. Without it arb_preempt is tied low
//   and ownership ends only when the owner drops its request.
// ----------------------------------------------------------------------------
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rest,
  bus_rr_arbiter_if.slave  bus
);

  if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_bad_hold_max
    $error("bus_rr_arbiter: HOLD_MAX must be in 2..255");
  end

  arb_state_e               state;
  logic [GRNT_ID_W-1:0]     last;
  logic [NUM_MASTERS-1:0]   grnt_p0;
  logic [GRNT_ID_W-1:0]     grnt_id_p0;
  logic                     vld_p0;

  logic [NUM_MASTERS-1:0]   req;
  logic [NUM_MASTERS-1:0]   pick;
  logic                     found;
  logic [GRNT_ID_W-1:0]     pick_id;
  logic                     owner_req;

  assign req       = {bus.m3_req, bus.m2_req, bus.m1_req, bus.m0_req};
  assign pick_id   = onehot_to_id(pick);
  // While OWNED, last is the current owner.
  assign owner_req = req[last];

  // In IDLE every master is eligible; while OWNED the owner is excluded, so
  // the same pick serves release handoffs and forced handoffs.
  rr_pick4 u_pick (
    .req   (req),
    .start (last),
    .excl  (state == ARB_OWNED),
    .pick  (pick),
    .found (found)
  );

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MAX);

  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  preempt_p0;
`endif

  // ---- registered grant stage (outputs come straight from these flops) ----
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state      <= ARB_IDLE;
      last       <= GRNT_ID_W'(NUM_MASTERS - 1);
      grnt_p0    <= '0;
      grnt_id_p0 <= '0;
      vld_p0     <= 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_cnt   <= '0;
      preempt_p0 <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_HOLD_LIMIT_EN
      preempt_p0 <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state      <= ARB_OWNED;
            last       <= pick_id;
            grnt_p0    <= pick;
            grnt_id_p0 <= pick_id;
            vld_p0     <= 1'b1;
`ifdef BUS_ARB_HOLD_LIMIT_EN
            hold_cnt   <= '0;
`endif
          end
        end
        ARB_OWNED: begin
          if (!owner_req) begin
            if (found) begin
              last       <= pick_id;
              grnt_p0    <= pick;
              grnt_id_p0 <= pick_id;
            end else begin
              state      <= ARB_IDLE;
              grnt_p0    <= '0;
              grnt_id_p0 <= '0;
              vld_p0     <= 1'b0;
            end
`ifdef BUS_ARB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
          end
`ifdef BUS_ARB_HOLD_LIMIT_EN
          else if ((hold_cnt == HOLD_LIM) && found) begin
            // Saturated owner with a waiter: rotate ownership away.
            last       <= pick_id;
            grnt_p0    <= pick;
            grnt_id_p0 <= pick_id;
            hold_cnt   <= '0;
            preempt_p0 <= 1'b1;
          end else if (hold_cnt != HOLD_LIM) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.m0_grnt  = grnt_p0[0];
  assign bus.m1_grnt  = grnt_p0[1];
  assign bus.m2_grnt  = grnt_p0[2];
  assign bus.m3_grnt  = grnt_p0[3];
  assign bus.grnt_id  = grnt_id_p0;
  assign bus.grnt_vld = vld_p0;

`ifdef BUS_ARB_HOLD_LIMIT_EN
  assign bus.arb_preempt = preempt_p0;
`else
  assign bus.arb_preempt = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//   Directed stimulus for bus_rr_arbiter with a behavioural ownership model
//   checked every falling edge, plus literal expectations at key points.
// ----------------------------------------------------------------------------
module tb_bus_rr_arbiter;
  import bus_rr_arbiter_pkg::*;

  localparam int HM = 4;
`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rest = 1'b0;
  logic [3:0] req_v = 4'b0000;

  bus_rr_arbiter_if bus ();

  assign bus.m0_req = req_v[0];
  assign bus.m1_req = req_v[1];
  assign bus.m2_req = req_v[2];
  assign bus.m3_req = req_v[3];

  bus_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  wire [3:0] dut_g = {bus.m3_grnt, bus.m2_grnt, bus.m1_grnt, bus.m0_grnt};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = -1 when the bus is free; last = most recent owner.
  int m_owner = -1;
  int m_last  = 3;
  int m_hold  = 0;
  bit m_pre   = 1'b0;

  // First requester after 'from' within n steps of the circular order.
  function automatic int first_after(input int from, input int n, input logic [3:0] r);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (from + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      m_owner = -1;
      m_last  = 3;
      m_hold  = 0;
      m_pre   = 1'b0;
    end else begin
      logic [3:0] r;
      int nxt;
      r     = req_v;
      m_pre = 1'b0;
      if (m_owner < 0) begin
        nxt = first_after(m_last, 4, r);
        if (nxt >= 0) begin
          m_owner = nxt;
          m_last  = nxt;
          m_hold  = 0;
        end
      end else if (!r[m_owner]) begin
        nxt     = first_after(m_owner, 3, r);
        m_owner = nxt;
        if (nxt >= 0) m_last = nxt;
        m_hold  = 0;
      end else if (HOLD_EN && (m_hold == HM) && (first_after(m_owner, 3, r) >= 0)) begin
        nxt     = first_after(m_owner, 3, r);
        m_owner = nxt;
        m_last  = nxt;
        m_hold  = 0;
        m_pre   = 1'b1;
      end else if (m_hold < HM) begin
        m_hold = m_hold + 1;
      end
    end
  end

  always @(negedge clk) begin
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    chk("model_grants", int'(dut_g), eg);
    chk("model_grnt_id", int'(bus.grnt_id), (m_owner >= 0) ? m_owner : 0);
    chk("model_grnt_vld", int'(bus.grnt_vld), (m_owner >= 0) ? 1 : 0);
    chk("model_preempt", int'(bus.arb_preempt), int'(m_pre));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_owner(input string name, input int id);
    chk({name, "_vld"}, int'(bus.grnt_vld), (id >= 0) ? 1 : 0);
    chk({name, "_id"}, int'(bus.grnt_id), (id >= 0) ? id : 0);
    chk({name, "_grants"}, int'(dut_g), (id >= 0) ? (1 << id) : 0);
  endtask

  initial begin
    // Reset held with every master requesting.
    req_v = 4'b1111;
    rest  = 1'b0;
    repeat (3) tick();
    expect_owner("reset", -1);
    chk("reset_preempt", int'(bus.arb_preempt), 0);

    rest = 1'b1;
    tick();
    expect_owner("after_reset_m0", 0);
    tick();
    expect_owner("m0_keeps", 0);

    // Asynchronous reset mid-ownership clears grants before any edge.
    rest = 1'b0;
    #1;
    expect_owner("async_reset", -1);
    tick();
    rest = 1'b1;
    tick();
    expect_owner("regrant_m0", 0);

    // Release chain m0 -> m1 -> m2 -> m3 -> idle.
    req_v = 4'b1110; tick(); expect_owner("hand_m1", 1);
    req_v = 4'b1100; tick(); expect_owner("hand_m2", 2);
    req_v = 4'b1000; tick(); expect_owner("hand_m3", 3);
    req_v = 4'b0000; tick(); expect_owner("rel_idle", -1);

    // m2 releases with only m0/m1 waiting: m3 skipped, m0 wins.
    req_v = 4'b0100; tick(); expect_owner("skip_m2", 2);
    req_v = 4'b0111; tick(); expect_owner("skip_m2_hold", 2);
    req_v = 4'b0011; tick(); expect_owner("skip_to_m0", 0);
    req_v = 4'b0000; tick(); expect_owner("skip_idle", -1);

    // Single master toggling: grant follows one cycle later with idle gaps.
    req_v = 4'b0010; tick(); expect_owner("tog_g1", 1);
    req_v = 4'b0000; tick(); expect_owner("tog_i1", -1);
    req_v = 4'b0010; tick(); expect_owner("tog_g2", 1);
    req_v = 4'b0000; tick(); expect_owner("tog_i2", -1);

    // m0 holds; m3 joins one cycle later.
    req_v = 4'b0001; tick(); expect_owner("hold_m0", 0);
    req_v = 4'b1001;
    for (int i = 0; i < HM; i++) begin
      tick();
      expect_owner("hold_m0_cont", 0);
      chk("hold_no_preempt", int'(bus.arb_preempt), 0);
    end
    tick();
    if (HOLD_EN) begin
      expect_owner("preempt_m3", 3);
      chk("preempt_pulse", int'(bus.arb_preempt), 1);
      tick();
      expect_owner("preempt_m3_keep", 3);
      chk("preempt_one_cycle", int'(bus.arb_preempt), 0);
    end else begin
      for (int i = 0; i < 10; i++) begin
        expect_owner("nolimit_m0", 0);
        chk("nolimit_preempt", int'(bus.arb_preempt), 0);
        tick();
      end
    end
    req_v = 4'b0000; tick(); expect_owner("hold_idle", -1);

    // m0 alone is never preempted.
    req_v = 4'b0001; tick(); expect_owner("alone_m0", 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_owner("alone_keep", 0);
      chk("alone_preempt", int'(bus.arb_preempt), 0);
    end
    req_v = 4'b0000; tick(); expect_owner("final_idle", -1);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
